fp_add_seq: RTL and testbench

- Multi-cycle IEEE-754 binary32 adder with valid/ready handshakes on input and output.
- It is the additive counterpart to the team's subtractor datapath and serves as the add stage of the floating-point arithmetic unit.
- One operation is in flight at a time.
- Fixed latency; round-to-nearest-even; subnormals flushed to zero.

---
 rtl/fp_pkg.sv | 41 ++++
 rtl/fp_lzc.sv | 18 +
 rtl/fp_add_seq.sv | 238 +++++++++++++++++++++++
 tb/tb_fp_add_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared constants, types and unpack helper for the binary32 adder
// Purpose : constants, the unpacked-operand struct, the adder state enum and
//           a flush-to-zero unpack function shared by the adder files.
// Ports   : none (package).
package fp_pkg;

  localparam int          EXP_BIAS = 127;
  localparam logic [31:0] QNAN     = 32'h7FC00000;
  localparam logic [31:0] POS_INF  = 32'h7F800000;

  // sig layout: [26] hidden bit, [25:3] stored mantissa, [2] guard, [1] round, [0] sticky
  typedef struct packed {
    logic        sign;
    logic [9:0]  exp;
    logic [26:0] sig;
  } fp_unpacked_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ADD   = 3'd2,
    ST_NORM  = 3'd3,
    ST_ROUND = 3'd4,
    ST_DONE  = 3'd5
  } fp_state_t;

  // Subnormals (exp field 0) become a signed zero with an all-zero significand.
  function automatic fp_unpacked_t fp_unpack(input logic [31:0] w);
    fp_unpacked_t u;
    u.sign = w[31];
    if (w[30:23] == 8'd0) begin
      u.exp = 10'd0;
      u.sig = 27'd0;
    end else begin
      u.exp = {2'b00, w[30:23]};
      u.sig = {1'b1, w[22:0], 3'b000};
    end
    return u;
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational 27-bit leading-zero counter
// Purpose : counts leading zeros of the extended significand for normalisation.
// Ports   : i_data  [26:0] value to scan (MSB first)
//           o_count [4:0]  number of leading zeros, 27 when i_data is zero
module fp_lzc (
  input  logic [26:0] i_data,
  output logic [4:0]  o_count
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_count = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (i_data[i]) o_count = 5'(26 - i);
    end
  end

endmodule

// File: rtl/fp_add_seq.sv
// rtl/fp_add_seq.sv - multi-cycle IEEE-754 binary32 adder with valid/ready handshakes
// Purpose : one operation in flight; IDLE -> ALIGN(2 cycles) -> ADD -> NORM -> ROUND
//           -> DONE, round-to-nearest-even, subnormals flushed to zero.
//           out_valid rises five clocks after the accepting edge.
// Ports   : clk, rst (async, active high)
//           in_valid/in_ready, a, b     operand handshake and binary32 operands
//           out_valid/out_ready, result  result handshake and binary32 sum
//           flags[2:0]                   {invalid, overflow, inexact}
//           op_sub                       only with FP_ADD_SUB_OP_EN: result = a - b
// Macro   : FP_ADD_SUB_OP_EN adds the op_sub port.
module fp_add_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
`ifdef FP_ADD_SUB_OP_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [2:0]             flags
);

  localparam logic [9:0] EXP_INF = 10'(2 * EXP_BIAS + 1);

  fp_state_t    r_state;
  fp_state_t    w_state_next;
  logic         r_in_ready;
  logic         r_align_ph;

  logic [31:0]  r_a;
  logic [31:0]  r_b;
  fp_unpacked_t r_ua;          // larger magnitude operand
  fp_unpacked_t r_ub;          // smaller magnitude operand, aligned in ALIGN phase 1
  logic         r_special;
  logic [31:0]  r_special_res;
  logic [2:0]   r_special_flags;
  logic [27:0]  r_sum;
  logic [9:0]   r_exp;
  logic [26:0]  r_norm_sig;
  logic         r_zero;
  logic [31:0]  r_result;
  logic [2:0]   r_flags;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      // Registered so in_ready stays low during reset and rises one clock after release.
      r_in_ready <= (w_state_next == ST_IDLE);
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (in_valid && r_in_ready) w_state_next = ST_ALIGN;
      ST_ALIGN: if (r_align_ph) w_state_next = ST_ADD;
      ST_ADD:   w_state_next = ST_NORM;
      ST_NORM:  w_state_next = ST_ROUND;
      ST_ROUND: w_state_next = ST_DONE;
      ST_DONE:  if (out_ready) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

  // ------------------------------------------- ALIGN phase 0: unpack, specials, swap
  fp_unpacked_t w_ua_raw;
  fp_unpacked_t w_ub_raw;
  logic         w_swap;
  logic         w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_invalid;
  logic [31:0]  w_special_res;

  always_comb begin
    w_ua_raw = fp_unpack(r_a);
    w_ub_raw = fp_unpack(r_b);
    w_swap   = {w_ub_raw.exp, w_ub_raw.sig} > {w_ua_raw.exp, w_ua_raw.sig};
    w_a_nan  = (&r_a[30:23]) & (|r_a[22:0]);
    w_b_nan  = (&r_b[30:23]) & (|r_b[22:0]);
    w_a_inf  = (&r_a[30:23]) & ~(|r_a[22:0]);
    w_b_inf  = (&r_b[30:23]) & ~(|r_b[22:0]);
    w_invalid = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (r_a[31] ^ r_b[31]));
    if (w_invalid)    w_special_res = QNAN;
    else if (w_a_inf) w_special_res = {r_a[31], POS_INF[30:0]};
    else              w_special_res = {r_b[31], POS_INF[30:0]};
  end

  // ------------------------------------------- ALIGN phase 1: shift smaller significand
  logic [9:0]  w_exp_diff;
  logic [26:0] w_mask;
  logic [26:0] w_b_shift;

  always_comb begin
    w_exp_diff = r_ua.exp - r_ub.exp;
    w_mask     = 27'd0;
    if (w_exp_diff >= 10'd26) begin
      // Everything lands below the round bit; only "was it nonzero" survives.
      w_b_shift = {26'd0, |r_ub.sig};
    end else begin
      w_mask    = ~(27'h7FFFFFF << w_exp_diff[4:0]);
      w_b_shift = (r_ub.sig >> w_exp_diff[4:0]) | {26'd0, |(r_ub.sig & w_mask)};
    end
  end

  // ------------------------------------------- ADD
  logic        w_eff_sub;
  logic [27:0] w_sum;

  assign w_eff_sub = r_ua.sign ^ r_ub.sign;
  // |A| >= |B| after the swap, so the difference never goes negative.
  assign w_sum = w_eff_sub ? ({1'b0, r_ua.sig} - {1'b0, r_ub.sig})
                           : ({1'b0, r_ua.sig} + {1'b0, r_ub.sig});

  // ------------------------------------------- NORM
  logic [4:0] w_lzc;

  fp_lzc u_lzc (
    .i_data  (r_sum[26:0]),
    .o_count (w_lzc)
  );

  // ------------------------------------------- ROUND
  logic        w_round_up;
  logic [24:0] w_mant;
  logic [9:0]  w_exp_rnd;
  logic        w_inexact;
  logic        w_zero_sign;
  logic [31:0] w_result;
  logic [2:0]  w_flags;

  always_comb begin
    w_round_up  = r_norm_sig[2] & (r_norm_sig[1] | r_norm_sig[0] | r_norm_sig[3]);
    w_mant      = {1'b0, r_norm_sig[26:3]} + {24'd0, w_round_up};
    w_exp_rnd   = w_mant[24] ? (r_exp + 10'd1) : r_exp;
    w_inexact   = |r_norm_sig[2:0];
    // Opposite signs cancelling give +0; like-signed zeros keep their sign.
    w_zero_sign = r_ua.sign & r_ub.sign;
    if (r_special) begin
      w_result = r_special_res;
      w_flags  = r_special_flags;
    end else if (r_zero) begin
      w_result = {w_zero_sign, 31'd0};
      w_flags  = 3'b000;
    end else if ($signed(w_exp_rnd) >= $signed(EXP_INF)) begin
      w_result = {r_ua.sign, POS_INF[30:0]};
      w_flags  = 3'b011;
    end else if ($signed(w_exp_rnd) <= 10'sd0) begin
      w_result = {r_ua.sign, 31'd0};
      w_flags  = 3'b001;
    end else begin
      // On a mantissa carry the significand is exactly 1.0, so the field bits are zero.
      w_result = {r_ua.sign, w_exp_rnd[7:0], (w_mant[24] ? w_mant[23:1] : w_mant[22:0])};
      w_flags  = {2'b00, w_inexact};
    end
  end

  // ------------------------------------------- datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_align_ph      <= 1'b0;
      r_a             <= 32'd0;
      r_b             <= 32'd0;
      r_ua            <= '0;
      r_ub            <= '0;
      r_special       <= 1'b0;
      r_special_res   <= 32'd0;
      r_special_flags <= 3'd0;
      r_sum           <= 28'd0;
      r_exp           <= 10'd0;
      r_norm_sig      <= 27'd0;
      r_zero          <= 1'b0;
      r_result        <= 32'd0;
      r_flags         <= 3'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_align_ph <= 1'b0;
          if (in_valid && r_in_ready) begin
            r_a <= a;
`ifdef FP_ADD_SUB_OP_EN
            r_b <= {b[EXP_W+MAN_W] ^ op_sub, b[EXP_W+MAN_W-1:0]};
`else
            r_b <= b;
`endif
          end
        end
        ST_ALIGN: begin
          r_align_ph <= ~r_align_ph;
          if (!r_align_ph) begin
            r_ua            <= w_swap ? w_ub_raw : w_ua_raw;
            r_ub            <= w_swap ? w_ua_raw : w_ub_raw;
            r_special       <= w_invalid | w_a_inf | w_b_inf;
            r_special_res   <= w_special_res;
            r_special_flags <= {w_invalid, 2'b00};
          end else begin
            r_ub.sig <= w_b_shift;
          end
        end
        ST_ADD: begin
          r_sum <= w_sum;
        end
        ST_NORM: begin
          r_zero <= (r_sum == 28'd0);
          if (r_sum[27]) begin
            // Carry out: shift right once, folding the dropped bit into sticky.
            r_norm_sig <= {r_sum[27:2], r_sum[1] | r_sum[0]};
            r_exp      <= r_ua.exp + 10'd1;
          end else begin
            r_norm_sig <= r_sum[26:0] << w_lzc;
            r_exp      <= r_ua.exp - {5'd0, w_lzc};
          end
        end
        ST_ROUND: begin
          r_result <= w_result;
          r_flags  <= w_flags;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_seq.sv
// tb/tb_fp_add_seq.sv - self-checking bench for fp_add_seq
`timescale 1ns/1ps
module tb_fp_add_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  flags;
`ifdef FP_ADD_SUB_OP_EN
  logic        op_sub = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  fp_add_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
`ifdef FP_ADD_SUB_OP_EN
    .op_sub    (op_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: exact signed sum of the two operands as wide integers, then RNE to 24 bits.
  function automatic logic [34:0] ref_add(input logic [31:0] x, input logic [31:0] y);
    int xe, ye, ex, ey, base, p, sh, be;
    logic [23:0] xm, ym;
    logic [131:0] vx, vy, mag, keep, rem, half, one;
    logic signed [131:0] sx, sy, s;
    bit xnan, ynan, xinf, yinf, inexact, neg;
    xe = int'(x[30:23]);
    ye = int'(y[30:23]);
    xnan = (xe == 255) && (x[22:0] != 0);
    ynan = (ye == 255) && (y[22:0] != 0);
    xinf = (xe == 255) && (x[22:0] == 0);
    yinf = (ye == 255) && (y[22:0] == 0);
    if (xnan || ynan || (xinf && yinf && (x[31] != y[31]))) return {3'b100, 32'h7FC00000};
    if (xinf) return {3'b000, x};
    if (yinf) return {3'b000, y};
    xm = (xe == 0) ? 24'd0 : {1'b1, x[22:0]};
    ym = (ye == 0) ? 24'd0 : {1'b1, y[22:0]};
    ex = (xe == 0) ? ye : xe;
    ey = (ye == 0) ? xe : ye;
    if (ex - ey <= 40 && ey - ex <= 40) begin
      base = (ex < ey) ? ex : ey;
      vx = {108'd0, xm} << (ex - base);
      vy = {108'd0, ym} << (ey - base);
    end else begin
      // The tiny operand only matters as a nonzero sliver far below the result's LSB.
      base = ((ex > ey) ? ex : ey) - 40;
      vx = (ex > ey) ? ({108'd0, xm} << 40) : 132'(xm != 0);
      vy = (ey > ex) ? ({108'd0, ym} << 40) : 132'(ym != 0);
    end
    sx = x[31] ? -$signed(vx) : $signed(vx);
    sy = y[31] ? -$signed(vy) : $signed(vy);
    s  = sx + sy;
    if (s == 0) return {3'b000, x[31] & y[31], 31'd0};
    neg = (s < 0);
    mag = neg ? -s : s;
    p = 0;
    for (int i = 131; i >= 0; i--) begin
      if (mag[i]) begin
        p = i;
        break;
      end
    end
    one = 132'd1;
    if (p > 23) begin
      sh   = p - 23;
      keep = mag >> sh;
      rem  = mag & ((one << sh) - one);
      half = one << (sh - 1);
      inexact = (rem != 0);
      if (rem > half || (rem == half && keep[0])) keep = keep + one;
    end else begin
      keep = mag << (23 - p);
      inexact = 1'b0;
    end
    be = p + base - 23;
    if (keep[24]) begin
      keep = keep >> 1;
      be++;
    end
    if (be >= 255) return {3'b011, neg, 8'hFF, 23'd0};
    if (be <= 0)   return {3'b001, neg, 31'd0};
    return {2'b00, inexact, neg, 8'(be), keep[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp(input int near_exp);
    int e;
    int mode;
    logic [22:0] m;
    mode = int'($urandom_range(0, 15));
    m = 23'($urandom);
    if (mode == 0) begin
      e = 255;
      if ($urandom_range(0, 1) == 0) m = 23'd0;
    end else if (mode == 1) begin
      e = 0;
    end else if (near_exp > 0 && mode < 11) begin
      e = near_exp + int'($urandom_range(0, 30)) - 15;
      if (e < 1) e = 1;
      if (e > 254) e = 254;
    end else begin
      e = int'($urandom_range(1, 254));
    end
    if (mode == 2) m = 23'($urandom_range(0, 3));
    return {1'($urandom), 8'(e), m};
  endfunction

  // Entered just after a rising edge; leaves just after the edge where out_valid rose.
  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb_, output int lat);
    int w;
    a = ta;
    b = tb_;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("in_ready_wait", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic [31:0] er, input logic [2:0] ef);
    int lat;
    start_op(ta, tb_, lat);
    chk({tag, "_lat"}, 32'(lat), 32'd5);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flags"}, {29'd0, flags}, {29'd0, ef});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] m;
    logic [31:0] ra, rb, held;
    int lat;
    int seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = 32'd0;
    b = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_in_ready_high", 32'(in_ready), 32'd1);

    run_op("one_plus_one", 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
    run_op("cancel",       32'h3F800000, 32'hBF800000, 32'h00000000, 3'b000);
    run_op("negzero",      32'h80000000, 32'h80000000, 32'h80000000, 3'b000);
    run_op("tie_even",     32'h3F800000, 32'h33800000, 32'h3F800000, 3'b001);
    run_op("above_tie",    32'h3F800000, 32'h33800001, 32'h3F800001, 3'b001);
    run_op("overflow",     32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b011);
    run_op("inf_minf",     32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b100);
    run_op("inf_fin",      32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000);
    run_op("subnorm_ftz",  32'h00400000, 32'h80000000, 32'h00000000, 3'b000);

    // Backpressure: result held while out_ready is low, new operands ignored.
    out_ready = 1'b0;
    start_op(32'h40000000, 32'h3F800000, lat);
    chk("bp_lat", 32'(lat), 32'd5);
    held = result;
    chk("bp_res", held, 32'h40400000);
    in_valid = 1'b1;
    a = 32'h3F800000;
    b = 32'h3F800000;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (result !== held || !out_valid || in_ready) seen++;
      @(posedge clk); #1;
    end
    chk("bp_stable_cycles_bad", 32'(seen), 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_out_valid_after", 32'(out_valid), 32'd0);
    chk("bp_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_no_extra_op", 32'(out_valid), 32'd0);

    // Reset abort while the operation sits in ADD.
    a = 32'h3F800000;
    b = 32'h3F800000;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_out_valid_rst", 32'(out_valid), 32'd0);
    chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("abort_no_result", 32'(seen), 32'd0);
    run_op("after_abort", 32'h40400000, 32'h3F800000, 32'h40800000, 3'b000);

    for (int n = 0; n < 60; n++) begin
      ra = rnd_fp(0);
      rb = rnd_fp(int'(ra[30:23]));
      m  = ref_add(ra, rb);
      run_op($sformatf("rnd%0d_%h_%h", n, ra, rb), ra, rb, m[31:0], m[34:32]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
